// File: rtl/btn_conditioner.sv
// N-channel pushbutton front end: 2-flop synchroniser, stable-time debouncer and a
// per-channel IDLE/PRESSED/REPEATING machine producing clean level, press/release
// pulses and optional hold-to-auto-repeat pulses. All outputs are registered.
module btn_conditioner #(
  parameter int unsigned      N_BTN         = 5,
  parameter int unsigned      STABLE_CYCLES = 6_500_000,
  parameter int unsigned      HOLD_CYCLES   = 50_000_000,
  parameter int unsigned      REPEAT_CYCLES = 10_000_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = 5'b11000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  localparam int unsigned StableW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned HoldW   = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned RepW    = $clog2(REPEAT_CYCLES + 1);

  localparam logic [StableW-1:0] StableLast = StableW'(STABLE_CYCLES - 1);
  localparam logic [HoldW-1:0]   HoldLast   = HoldW'(HOLD_CYCLES - 1);
  localparam logic [RepW-1:0]    RepLast    = RepW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StRepeating
  } state_e;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    localparam bit RepEn = REPEAT_MASK[i];

    logic [1:0]         sync_q;
    logic [StableW-1:0] deb_cnt_q, deb_cnt_d;
    logic               deb_q, deb_d;
    state_e             state_q, state_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [RepW-1:0]    rep_q, rep_d;
    logic               press_d, release_d, long_d;
    logic               level_q, press_q, release_q, long_q;

    // Two-flop synchroniser; sync_q[1] is the synced button value.
    always_ff @(posedge clk) begin
      if (!rst) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[0], btn_in[i]};
      end
    end

    // Debounce: count consecutive mismatching cycles, accept the new level once stable.
    always_comb begin
      deb_cnt_d = deb_cnt_q;
      deb_d     = deb_q;
      if (sync_q[1] == deb_q) begin
        deb_cnt_d = '0;
      end else if (deb_cnt_q == StableLast) begin
        deb_d     = sync_q[1];
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end

    // Debounce state.
    always_ff @(posedge clk) begin
      if (!rst) begin
        deb_cnt_q <= '0;
        deb_q     <= 1'b0;
      end else begin
        deb_cnt_q <= deb_cnt_d;
        deb_q     <= deb_d;
      end
    end

    // FSM state register with hold and repeat counters.
    always_ff @(posedge clk) begin
      if (!rst) begin
        state_q <= StIdle;
        hold_q  <= '0;
        rep_q   <= '0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        rep_q   <= rep_d;
      end
    end

    // FSM next state; counters clear on every state change and every repeat pulse.
    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      rep_d   = rep_q;
      unique case (state_q)
        StIdle: begin
          hold_d = '0;
          rep_d  = '0;
          if (deb_q) begin
            state_d = StPressed;
          end
        end
        StPressed: begin
          if (!deb_q) begin
            state_d = StIdle;
            hold_d  = '0;
          end else if (RepEn) begin
            if (hold_q == HoldLast) begin
              state_d = StRepeating;
              hold_d  = '0;
              rep_d   = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        StRepeating: begin
          if (!deb_q) begin
            state_d = StIdle;
            rep_d   = '0;
          end else if (rep_q == RepLast) begin
            rep_d = '0;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // FSM outputs; a release takes priority over a coincident due repeat.
    always_comb begin
      press_d   = 1'b0;
      release_d = 1'b0;
      unique case (state_q)
        StIdle: press_d = deb_q;
        StPressed: begin
          if (!deb_q) begin
            release_d = 1'b1;
          end else if (RepEn && (hold_q == HoldLast)) begin
            press_d = 1'b1;
          end
        end
        StRepeating: begin
          if (!deb_q) begin
            release_d = 1'b1;
          end else if (rep_q == RepLast) begin
            press_d = 1'b1;
          end
        end
        default: ;
      endcase
      long_d = (state_d == StRepeating);
    end

    // Output registers.
    always_ff @(posedge clk) begin
      if (!rst) begin
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        level_q   <= deb_q;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_long[i]    = long_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a pulse-event scoreboard.
module tb_btn_conditioner;

  localparam int unsigned NBtn = 3;

  logic            clk;
  logic            rst;
  logic [NBtn-1:0] btn_in;
  logic [NBtn-1:0] btn_level;
  logic [NBtn-1:0] btn_press;
  logic [NBtn-1:0] btn_release;
  logic [NBtn-1:0] btn_long;

  btn_conditioner #(
    .N_BTN        (NBtn),
    .STABLE_CYCLES(8),
    .HOLD_CYCLES  (20),
    .REPEAT_CYCLES(5),
    .REPEAT_MASK  (3'b010)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [2:0]  press;
    logic [2:0]  rel;
  } ev_t;

  ev_t exp_q[$];
  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input int c, input logic [2:0] p, input logic [2:0] r);
    ev_t e;
    e.cyc   = c;
    e.press = p;
    e.rel   = r;
    exp_q.push_back(e);
  endtask

  // One clock; outputs sampled 1 time unit after the edge and matched to the scoreboard.
  task automatic tick();
    ev_t e;
    @(posedge clk);
    #1;
    cyc++;
    chk("long_nonrep", {30'b0, btn_long[2], btn_long[0]}, 32'd0);
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("sb_missed_event_cyc", cyc, e.cyc);
    end
    if (btn_press != 3'b000 || btn_release != 3'b000) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_pulse", {26'b0, btn_press, btn_release}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_cyc", cyc, e.cyc);
        chk("sb_press", btn_press, e.press);
        chk("sb_release", btn_release, e.rel);
      end
    end
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick();
  endtask

  initial begin
    int c;
    int p;
    int r;

    // Reset with all buttons held.
    rst    = 1'b0;
    btn_in = 3'b111;
    tick_n(4);
    chk("rst_level", btn_level, 0);
    chk("rst_press", btn_press, 0);
    chk("rst_release", btn_release, 0);
    chk("rst_long", btn_long, 0);
    rst = 1'b1;
    c   = cyc;
    push(c + 11, 3'b111, 3'b000);
    tick_to(c + 10);
    chk("rst_level_pre", btn_level, 0);
    tick();
    chk("rst_level_post", btn_level, 3'b111);
    btn_in = 3'b000;
    push(cyc + 11, 3'b000, 3'b111);
    tick_to(cyc + 11);
    chk("rst_rel_level", btn_level, 0);

    // Glitch of 7 cycles on ch2 is rejected.
    btn_in = 3'b100;
    tick_n(7);
    btn_in = 3'b000;
    tick_n(20);
    chk("glitch_level", btn_level, 0);

    // Exactly 8 cycles on ch2 is accepted.
    c      = cyc;
    btn_in = 3'b100;
    push(c + 11, 3'b100, 3'b000);
    tick_n(8);
    btn_in = 3'b000;
    push(c + 19, 3'b000, 3'b100);
    tick_to(c + 11);
    chk("edge8_level", btn_level, 3'b100);
    tick_to(c + 21);
    chk("edge8_level_low", btn_level, 0);

    // Bouncing ch0, then held 100 cycles on a non-repeat channel.
    for (int s = 0; s < 10; s++) begin
      btn_in = (s % 2 == 0) ? 3'b001 : 3'b000;
      tick_n(3);
    end
    chk("bounce_level", btn_level, 0);
    c      = cyc;
    btn_in = 3'b001;
    push(c + 11, 3'b001, 3'b000);
    tick_to(c + 11);
    chk("bounce_level_hi", btn_level, 3'b001);
    tick_to(c + 100);
    chk("hold0_level", btn_level, 3'b001);
    chk("hold0_long", btn_long, 0);
    btn_in = 3'b000;
    push(c + 111, 3'b000, 3'b001);
    tick_to(c + 115);
    chk("hold0_level_low", btn_level, 0);

    // Auto-repeat on ch1; release coincides with a due repeat and cancels it.
    c      = cyc;
    p      = c + 11;
    btn_in = 3'b010;
    push(p, 3'b010, 3'b000);
    for (int j = 0; j < 8; j++) push(p + 20 + 5 * j, 3'b010, 3'b000);
    tick_to(p + 19);
    chk("rep_long_pre", btn_long, 0);
    tick();
    chk("rep_long_on", btn_long, 3'b010);
    tick_to(p + 49);
    btn_in = 3'b000;
    push(p + 60, 3'b000, 3'b010);
    tick_to(p + 59);
    chk("rep_long_hold", btn_long, 3'b010);
    chk("rep_level_hold", btn_level, 3'b010);
    tick();
    chk("rep_long_off", btn_long, 0);
    chk("rep_level_off", btn_level, 0);
    tick_n(5);

    // Reset while repeating, button still held.
    c      = cyc;
    p      = c + 11;
    btn_in = 3'b010;
    push(p, 3'b010, 3'b000);
    push(p + 20, 3'b010, 3'b000);
    tick_to(p + 22);
    chk("mid_long", btn_long, 3'b010);
    rst = 1'b0;
    tick();
    chk("mid_rst_level", btn_level, 0);
    chk("mid_rst_press", btn_press, 0);
    chk("mid_rst_release", btn_release, 0);
    chk("mid_rst_long", btn_long, 0);
    rst = 1'b1;
    r   = cyc;
    push(r + 11, 3'b010, 3'b000);
    tick_to(r + 10);
    chk("mid_level_pre", btn_level, 0);
    tick();
    chk("mid_level_post", btn_level, 3'b010);
    btn_in = 3'b000;
    push(r + 22, 3'b000, 3'b010);
    tick_to(r + 30);

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Parametrised N-channel pushbutton front end for the timer/stopwatch top level: synchronises raw buttons, debounces them with a stable-time counter, and produces clean levels, one-cycle press/release pulses and optional hold-to-auto-repeat pulses. It replaces the per-button debouncers in the top level. The inc_min/inc_sec buttons use auto-repeat so a held button keeps incrementing; start/stop/soft-reset use plain press pulses.

## Interface
Parameters:
- N_BTN, 5: number of button channels.
- STABLE_CYCLES, 6_500_000: consecutive stable cycles required to accept a new level (65 ms at 100 MHz). Must be ≥1.
- HOLD_CYCLES, 50_000_000: cycles the debounced level must stay high before auto-repeat starts (500 ms). Must be ≥1.
- REPEAT_CYCLES, 10_000_000: period of repeat pulses once repeating (100 ms). Must be ≥1.
- REPEAT_MASK, 5'b11000: bit i = 1 enables auto-repeat on channel i.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset; one clock; reset is synchronous and active-low (rst=0 resets on the rising clk edge).
- btn_in  in  N_BTN  raw asynchronous buttons, active-high.
- btn_level  out  N_BTN  debounced level.
- btn_press  out  N_BTN  one-cycle pulse on each accepted press and each auto-repeat.
- btn_release  out  N_BTN  one-cycle pulse on each accepted release.
- btn_long  out  N_BTN  high while a repeat-enabled channel is in REPEATING.

## Operation
- Per channel: 2-flop synchroniser (reset to 0) -> debounce counter -> state machine. Channels fully independent.
- Debounce: counter width $clog2(STABLE_CYCLES+1). Cleared on any cycle where synced value equals btn_level; otherwise increments. When it reaches STABLE_CYCLES-1 while mismatched, btn_level takes the synced value on that edge and the counter clears. Any glitch shorter than STABLE_CYCLES cycles produces no output change.
- State machine per channel, states IDLE, PRESSED, REPEATING:
  - IDLE: btn_level rising -> PRESSED, btn_press=1 for that cycle, hold counter cleared.
  - PRESSED: btn_level falling -> IDLE with btn_release pulse. If REPEAT_MASK[i]=1 and hold counter reaches HOLD_CYCLES -> REPEATING, btn_press pulse, btn_long=1, repeat counter cleared. If REPEAT_MASK[i]=0, stays PRESSED indefinitely.
  - REPEATING: btn_press pulse every REPEAT_CYCLES cycles; btn_level falling -> IDLE, btn_release pulse, btn_long=0 on same edge.
- Hold/repeat counters sized $clog2(max+1); no wrap: they clear on every state change and on every repeat pulse.
- Press and release never pulse on the same cycle in one channel; a release edge cancels a coincident due repeat pulse.
- Button held through reset: after rst returns high the channel debounces from 0 and produces a normal press pulse.

## Timing
- Reset values: btn_level, btn_press, btn_release, btn_long all 0; all states IDLE; all counters 0.
- Latency: raw change first sampled at edge k -> btn_level (and press/release pulse) changes at edge k+STABLE_CYCLES+2, registered.
- First repeat pulse HOLD_CYCLES cycles after the initial press pulse; subsequent pulses every REPEAT_CYCLES cycles.
- All outputs registered; no combinational path from btn_in.
- rst low mid-press: everything returns to reset values on that edge, no release pulse emitted.

## Test plan
Bench parameters: N_BTN=3, STABLE_CYCLES=8, HOLD_CYCLES=20, REPEAT_CYCLES=5, REPEAT_MASK=3'b010.
- Reset: hold rst=0 for 4 cycles with btn_in=3'b111 -> all outputs 0; after release, btn_level=3'b111 exactly 10 cycles later with btn_press=3'b111 for one cycle.
- Bounce: ch0 toggles every 3 cycles for 30 cycles then stays high -> exactly one btn_press[0] pulse, 10 cycles after final rise sample; no release pulses.
- Glitch: ch2 high for 7 cycles then low -> btn_level[2], btn_press[2] stay 0.
- Auto-repeat: ch1 held 60 cycles after acceptance -> press pulses at offsets 0, 20, 25, 30, ..., 55; btn_long[1] high from offset 20; release pulse and btn_long=0 10 cycles after drop.
- Non-repeat channel: ch0 held 100 cycles -> single press pulse, btn_long[0]=0 throughout, one release pulse.
- Reset mid-repeat: ch1 in REPEATING, rst=0 one cycle -> all outputs 0 next cycle, no release pulse; btn_in still high -> new press 10 cycles after rst=1.
